// File: rtl/ddr4_db_dir_ctrl.sv
// Per-lane DQ/DQS direction controller for the DDR4 RDIMM data-buffer delay model.
// Turns READ/WRITE commands into latency-aligned drive windows; write leveling overrides.
module ddr4_db_dir_ctrl #(
  parameter int unsigned CS_NUM = 2,
  parameter int unsigned CL     = 11,
  parameter int unsigned CWL    = 9,
  parameter int unsigned PRE    = 1,
  parameter int unsigned BURST  = 4,
  parameter int unsigned POST   = 1
) (
  input  logic              ddr_ck,
  input  logic              ddr_rst,
  input  logic              initDone,
  input  logic              ddr_act_n,
  input  logic [CS_NUM-1:0] ddr_cs_n,
  input  logic [16:14]      ddr_a,
  input  logic              db_dly_dir,
  output logic              dir_wr,
  output logic              dir_rd,
  output logic              wl_mode,
  output logic              conflict,
  output logic              idle
);

  localparam int unsigned MaxLat = (CL > CWL) ? CL : CWL;
  localparam int unsigned W      = MaxLat + BURST + POST + 1;
  localparam int unsigned RunLen = PRE + BURST + POST;

  localparam logic [W-1:0] RunOnes = {W{1'b1}} >> (W - RunLen);
  localparam logic [W-1:0] WrRun   = RunOnes << (CWL - PRE);
  localparam logic [W-1:0] RdRun   = RunOnes << (CL - PRE);

  // The preamble must fit after the command edge, otherwise the run offset goes negative.
  generate
    if (CL <= PRE || CWL <= PRE) begin : g_bad_latency
      $fatal(1, "ddr4_db_dir_ctrl: CL and CWL must both exceed PRE");
    end
  endgenerate

  logic [W-1:0] wr_sched_q, wr_sched_d;
  logic [W-1:0] rd_sched_q, rd_sched_d;
  logic         cmd_valid;

  always_comb begin
    cmd_valid  = initDone && ddr_act_n && (|(~ddr_cs_n)) && (ddr_a[16:15] == 2'b10);
    wr_sched_d = wr_sched_q >> 1;
    rd_sched_d = rd_sched_q >> 1;
    if (db_dly_dir) begin
      wr_sched_d = '0;
      rd_sched_d = '0;
    end else if (cmd_valid) begin
      if (ddr_a[14]) begin
        rd_sched_d = rd_sched_d | RdRun;
      end else begin
        wr_sched_d = wr_sched_d | WrRun;
      end
    end
  end

  // Outputs are registered from the next-state bit 0 so they line up with the schedules.
  always_ff @(posedge ddr_ck) begin
    if (ddr_rst) begin
      wr_sched_q <= '0;
      rd_sched_q <= '0;
      dir_wr     <= 1'b0;
      dir_rd     <= 1'b0;
      wl_mode    <= 1'b0;
      conflict   <= 1'b0;
      idle       <= 1'b1;
    end else begin
      wr_sched_q <= wr_sched_d;
      rd_sched_q <= rd_sched_d;
      dir_wr     <= wr_sched_d[0];
      dir_rd     <= rd_sched_d[0] & ~wr_sched_d[0];
      wl_mode    <= db_dly_dir;
      conflict   <= conflict | (wr_sched_d[0] & rd_sched_d[0]);
      idle       <= ~(|wr_sched_d) & ~(|rd_sched_d);
    end
  end

endmodule

// File: tb/tb_ddr4_db_dir_ctrl.sv
// Bench for ddr4_db_dir_ctrl: directed test-plan scenarios, then random traffic checked
// against a per-edge timeline model of the drive windows.
module tb_ddr4_db_dir_ctrl;

  localparam int unsigned CS_NUM = 2;
  localparam int unsigned CL     = 11;
  localparam int unsigned CWL    = 9;
  localparam int unsigned PRE    = 1;
  localparam int unsigned BURST  = 4;
  localparam int unsigned POST   = 1;
  localparam int          TMAX   = 4096;

  localparam logic [2:0] NOP = 3'b111;
  localparam logic [2:0] WR  = 3'b100;
  localparam logic [2:0] RD  = 3'b101;

  logic              ddr_ck;
  logic              ddr_rst;
  logic              initDone;
  logic              ddr_act_n;
  logic [CS_NUM-1:0] ddr_cs_n;
  logic [16:14]      ddr_a;
  logic              db_dly_dir;
  logic              dir_wr;
  logic              dir_rd;
  logic              wl_mode;
  logic              conflict;
  logic              idle;

  ddr4_db_dir_ctrl #(
    .CS_NUM(CS_NUM),
    .CL    (CL),
    .CWL   (CWL),
    .PRE   (PRE),
    .BURST (BURST),
    .POST  (POST)
  ) dut (
    .ddr_ck    (ddr_ck),
    .ddr_rst   (ddr_rst),
    .initDone  (initDone),
    .ddr_act_n (ddr_act_n),
    .ddr_cs_n  (ddr_cs_n),
    .ddr_a     (ddr_a),
    .db_dly_dir(db_dly_dir),
    .dir_wr    (dir_wr),
    .dir_rd    (dir_rd),
    .wl_mode   (wl_mode),
    .conflict  (conflict),
    .idle      (idle)
  );

  initial begin
    ddr_ck = 1'b0;
    forever #5 ddr_ck = ~ddr_ck;
  end

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Timeline model: busy[t] means that type drives the bus after edge t.
  bit   wr_busy [TMAX];
  bit   rd_busy [TMAX];
  logic m_conf = 1'b0;
  logic m_wl   = 1'b0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b at edge %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_from(input int t);
    for (int j = 0; j < 64; j++) begin
      wr_busy[t+j] = 1'b0;
      rd_busy[t+j] = 1'b0;
    end
  endtask

  task automatic mark(input logic is_rd, input int t);
    int start;
    start = t + int'(is_rd ? CL : CWL) - int'(PRE);
    for (int j = 0; j < int'(PRE + BURST + POST); j++) begin
      if (is_rd) rd_busy[start+j] = 1'b1;
      else       wr_busy[start+j] = 1'b1;
    end
  endtask

  // One clock: drive at negedge, update the model at posedge, compare #1 later.
  task automatic step(input logic [2:0] a, input logic [1:0] cs, input logic init,
                      input logic act_n, input logic dly, input logic rst);
    logic cmd;
    logic busy_ahead;
    @(negedge ddr_ck);
    ddr_a      = a;
    ddr_cs_n   = cs;
    initDone   = init;
    ddr_act_n  = act_n;
    db_dly_dir = dly;
    ddr_rst    = rst;
    @(posedge ddr_ck);
    cmd = init && act_n && (cs != 2'b11) && (a[2:1] == 2'b10);
    if (rst) begin
      clear_from(cyc);
      m_conf = 1'b0;
      m_wl   = 1'b0;
    end else begin
      if (dly) clear_from(cyc);
      else if (cmd) mark(a[0], cyc);
      m_wl = dly;
      if (wr_busy[cyc] && rd_busy[cyc]) m_conf = 1'b1;
    end
    busy_ahead = 1'b0;
    for (int j = 0; j < 64; j++) busy_ahead = busy_ahead | wr_busy[cyc+j] | rd_busy[cyc+j];
    #1;
    chk("dir_wr", dir_wr, wr_busy[cyc]);
    chk("dir_rd", dir_rd, rd_busy[cyc] & ~wr_busy[cyc]);
    chk("wl_mode", wl_mode, m_wl);
    chk("conflict", conflict, m_conf);
    chk("idle", idle, ~busy_ahead);
    cyc++;
  endtask

  task automatic cmd_step(input logic [2:0] a);
    step(a, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(NOP, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  int dly_left;

  initial begin
    ddr_rst = 1'b1; initDone = 1'b0; ddr_act_n = 1'b1; ddr_cs_n = 2'b11;
    ddr_a = NOP; db_dly_dir = 1'b0;

    do_reset();
    do_reset();
    chk("reset_idle", idle, 1'b1);
    chk("reset_conflict", conflict, 1'b0);
    chk("reset_dir_wr", dir_wr, 1'b0);

    // Single WRITE
    for (int r = 0; r <= 16; r++) begin
      cmd_step(r == 0 ? WR : NOP);
      chk("sw_dir_wr", dir_wr, logic'(r >= 8 && r <= 13));
      chk("sw_dir_rd", dir_rd, 1'b0);
      if (r >= 1 && r <= 13) chk("sw_idle_busy", idle, 1'b0);
      if (r >= 14) chk("sw_idle_done", idle, 1'b1);
    end

    // Single READ, driven on the other chip select
    for (int r = 0; r <= 18; r++) begin
      step(r == 0 ? RD : NOP, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("sr_dir_rd", dir_rd, logic'(r >= 10 && r <= 15));
      chk("sr_conflict", conflict, 1'b0);
    end

    // Back-to-back writes, both chip selects low
    for (int r = 0; r <= 20; r++) begin
      step((r == 0 || r == 4) ? WR : NOP, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("b2b_dir_wr", dir_wr, logic'(r >= 8 && r <= 17));
    end

    // Read/write collision
    for (int r = 0; r <= 22; r++) begin
      cmd_step(r == 0 ? WR : (r == 2 ? RD : NOP));
      chk("col_dir_wr", dir_wr, logic'(r >= 8 && r <= 13));
      chk("col_dir_rd", dir_rd, logic'(r >= 14 && r <= 17));
      chk("col_conflict", conflict, logic'(r >= 12));
    end
    do_reset();
    chk("col_conflict_cleared", conflict, 1'b0);

    // Write-leveling interrupt
    for (int r = 0; r <= 33; r++) begin
      step((r == 0 || r == 18) ? WR : (r == 12 ? RD : NOP), 2'b10, 1'b1, 1'b1,
           logic'(r >= 9 && r <= 15), 1'b0);
      chk("wl_dir_wr", dir_wr, logic'(r == 8 || (r >= 26 && r <= 31)));
      chk("wl_dir_rd", dir_rd, 1'b0);
      if (r <= 8 || r >= 16) chk("wl_mode_low", wl_mode, 1'b0);
      if (r >= 10 && r <= 15) chk("wl_mode_high", wl_mode, 1'b1);
    end

    // Reset landing on the first edge of a READ window
    for (int r = 0; r <= 24; r++) begin
      step(r == 0 ? RD : NOP, 2'b10, 1'b1, 1'b1, 1'b0, logic'(r == 10));
      chk("rst_dir_rd", dir_rd, 1'b0);
      if (r == 9) chk("rst_idle_before", idle, 1'b0);
      if (r >= 10) chk("rst_idle_after", idle, 1'b1);
    end

    // Commands while initDone is low
    for (int r = 0; r <= 20; r++) begin
      step(r == 0 ? WR : (r == 1 ? RD : NOP), 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("init_dir_wr", dir_wr, 1'b0);
      chk("init_dir_rd", dir_rd, 1'b0);
      chk("init_idle", idle, 1'b1);
    end

    // Random traffic against the timeline model
    dly_left = 0;
    for (int i = 0; i < 700; i++) begin
      logic [2:0] a;
      int         sel;
      logic       dly;
      sel = int'($urandom_range(0, 9));
      if (sel < 2)       a = WR;
      else if (sel < 4)  a = RD;
      else if (sel == 4) a = 3'($urandom_range(0, 7));
      else               a = NOP;
      if (dly_left == 0 && $urandom_range(0, 59) == 0) dly_left = int'($urandom_range(1, 6));
      dly = (dly_left > 0);
      if (dly_left > 0) dly_left--;
      step(a, 2'($urandom_range(0, 3)), logic'($urandom_range(0, 19) != 0),
           logic'($urandom_range(0, 9) != 0), dly, logic'($urandom_range(0, 149) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
